// File: rtl/ddr3_wb_traffic_checker.sv
// Wishbone pipelined traffic generator/checker for DDR3 bring-up: writes a seeded
// pattern to NUM_TRANSFERS burst addresses, reads them back and reports the result.
module ddr3_wb_traffic_checker #(
  parameter int unsigned WB_DATA_BITS    = 512,
  parameter int unsigned WB_ADDR_BITS    = 24,
  parameter int unsigned NUM_TRANSFERS   = 256,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned ODD_STRIDE      = 37,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                      i_controller_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [31:0]               i_seed,
  input  logic [WB_ADDR_BITS-1:0]   i_base_addr,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [WB_ADDR_BITS-1:0]   o_wb_addr,
  output logic [WB_DATA_BITS-1:0]   o_wb_data,
  output logic [WB_DATA_BITS/8-1:0] o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic [WB_DATA_BITS-1:0]   i_wb_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic                      o_timeout,
  output logic [15:0]               o_err_count,
  output logic [WB_ADDR_BITS-1:0]   o_first_err_addr
);

  localparam int unsigned LANES = WB_DATA_BITS / 32;
  localparam int unsigned IDX_W = $clog2(NUM_TRANSFERS) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRANSFERS - 1);
  localparam logic [IDX_W-1:0] ALL_IDX  = IDX_W'(NUM_TRANSFERS);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_WACK, S_READ, S_WAIT_RACK, S_DONE
  } state_t;

  function automatic logic [WB_ADDR_BITS-1:0] addr_of(input logic [IDX_W-1:0] idx,
                                                      input logic mode,
                                                      input logic [WB_ADDR_BITS-1:0] base);
    logic [31:0] off;
    off = mode ? ((32'(idx) * 32'(ODD_STRIDE)) & 32'(NUM_TRANSFERS - 1)) : 32'(idx);
    return base + WB_ADDR_BITS'(off);
  endfunction

  function automatic logic [WB_DATA_BITS-1:0] pattern_of(input logic [WB_ADDR_BITS-1:0] addr,
                                                         input logic [31:0] seed);
    logic [WB_DATA_BITS-1:0] d;
    logic [31:0] a;
    a = 32'(addr);
    for (int unsigned k = 0; k < LANES; k++)
      d[32*k +: 32] = (a * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA77) ^ seed;
    return d;
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        issue_idx, issue_d, ack_idx, ack_idx_d;
  logic [OUT_W-1:0]        outstanding, out_d;
  logic [TO_W-1:0]         to_cnt, to_d;
  logic                    mode_q, mode_d;
  logic [WB_ADDR_BITS-1:0] base_q, base_d, addr_d, rd_addr;
  logic [31:0]             seed_q, seed_d;
  logic [15:0]             err_d;
  logic                    active, active_d, issuing_d, start_go, accept, ack_v, rd_ack;
  logic                    to_hit, timeout_d, mismatch, stb_d;

  // handshake qualification and timeout detection
  always_comb begin
    active   = (state_q == S_WRITE) || (state_q == S_WAIT_WACK) ||
               (state_q == S_READ)  || (state_q == S_WAIT_RACK);
    start_go = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    accept   = o_wb_stb && !i_wb_stall;
    ack_v    = i_wb_ack && active && (outstanding != '0);
    rd_ack   = ack_v && ((state_q == S_READ) || (state_q == S_WAIT_RACK));
    to_hit   = active && !ack_v && (outstanding != '0) && (to_cnt == TO_LAST);
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_go) state_d = S_WRITE;
      S_WRITE: begin
        if (to_hit)                                state_d = S_DONE;
        else if (accept && (issue_idx == LAST_IDX)) state_d = S_WAIT_WACK;
      end
      S_WAIT_WACK: begin
        if (to_hit)                   state_d = S_DONE;
        else if (outstanding == '0)   state_d = S_READ;
      end
      S_READ: begin
        if (to_hit)                                state_d = S_DONE;
        else if (accept && (issue_idx == LAST_IDX)) state_d = S_WAIT_RACK;
      end
      S_WAIT_RACK: begin
        if (to_hit)                    state_d = S_DONE;
        else if (ack_idx == ALL_IDX)   state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // next values of counters, captured configuration and bus drive
  always_comb begin
    mode_d = start_go ? i_mode      : mode_q;
    base_d = start_go ? i_base_addr : base_q;
    seed_d = start_go ? i_seed      : seed_q;

    issue_d = issue_idx + IDX_W'(accept);
    if (start_go || ((state_q == S_WAIT_WACK) && (state_d == S_READ))) issue_d = '0;
    out_d     = start_go ? '0 : (outstanding + OUT_W'(accept) - OUT_W'(ack_v));
    ack_idx_d = start_go ? '0 : (ack_idx + IDX_W'(rd_ack));
    to_d      = (!active || ack_v || (outstanding == '0)) ? '0 : (to_cnt + TO_W'(1));

    rd_addr  = addr_of(ack_idx, mode_q, base_q);
    mismatch = rd_ack && (i_wb_data != pattern_of(rd_addr, seed_q));
    err_d    = o_err_count;
    if (start_go)                                  err_d = '0;
    else if (mismatch && (o_err_count != 16'hFFFF)) err_d = o_err_count + 16'd1;
    timeout_d = to_hit || (o_timeout && !start_go);

    active_d  = (state_d == S_WRITE) || (state_d == S_WAIT_WACK) ||
                (state_d == S_READ)  || (state_d == S_WAIT_RACK);
    issuing_d = (state_d == S_WRITE) || (state_d == S_READ);
    stb_d     = issuing_d && (issue_d != ALL_IDX) && (out_d != MAX_OUT);
    addr_d    = addr_of(issue_d, mode_d, base_d);
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      issue_idx        <= '0;
      ack_idx          <= '0;
      outstanding      <= '0;
      to_cnt           <= '0;
      mode_q           <= 1'b0;
      base_q           <= '0;
      seed_q           <= '0;
      o_wb_cyc         <= 1'b0;
      o_wb_stb         <= 1'b0;
      o_wb_we          <= 1'b0;
      o_wb_addr        <= '0;
      o_wb_data        <= '0;
      o_wb_sel         <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
    end else begin
      issue_idx   <= issue_d;
      ack_idx     <= ack_idx_d;
      outstanding <= out_d;
      to_cnt      <= to_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      o_wb_cyc    <= active_d;
      o_wb_stb    <= stb_d;
      o_wb_we     <= (state_d == S_WRITE) || (state_d == S_WAIT_WACK);
      o_wb_sel    <= stb_d ? '1 : '0;
      // address and data only advance while issuing, so they hold through stalls
      if (issuing_d) begin
        o_wb_addr <= addr_d;
        o_wb_data <= pattern_of(addr_d, seed_d);
      end
      o_busy      <= active_d;
      o_done      <= (state_d == S_DONE);
      o_pass      <= (state_d == S_DONE) && (err_d == '0) && !timeout_d;
      o_timeout   <= timeout_d;
      o_err_count <= err_d;
      if (start_go)                             o_first_err_addr <= '0;
      else if (mismatch && (o_err_count == '0)) o_first_err_addr <= rd_addr;
    end
  end

endmodule

// File: tb/tb_ddr3_wb_traffic_checker.sv
// Randomised bench for ddr3_wb_traffic_checker: a pipelined Wishbone memory slave
// with configurable latency, stall rate, corruption and ack cut-off.
module tb_ddr3_wb_traffic_checker;

  localparam int unsigned DW = 512, AW = 24, N = 256, MAXO = 16, STRIDE = 37, TO = 4096;
  localparam int unsigned LANES = DW / 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, mode;
  logic [31:0]   seed;
  logic [AW-1:0] base;
  logic          cyc, stb, we, busy, done, pass, tmo;
  logic [AW-1:0] wb_addr, ferr;
  logic [DW-1:0] wb_data, slv_rdata, inj_data, rdata_in;
  logic [DW/8-1:0] sel;
  logic [15:0]   err;
  logic          slv_stall, slv_ack, inj_ack, ack_in;

  assign ack_in   = slv_ack | inj_ack;
  assign rdata_in = inj_ack ? inj_data : slv_rdata;

  ddr3_wb_traffic_checker #(
    .WB_DATA_BITS(DW), .WB_ADDR_BITS(AW), .NUM_TRANSFERS(N),
    .MAX_OUTSTANDING(MAXO), .ODD_STRIDE(STRIDE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_controller_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_seed(seed), .i_base_addr(base),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_data), .o_wb_sel(sel),
    .i_wb_stall(slv_stall), .i_wb_ack(ack_in), .i_wb_data(rdata_in),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
    .o_err_count(err), .o_first_err_addr(ferr)
  );

  int n_cmp = 0, n_fail = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // slave knobs and observations
  int lat = 1, stall_pct = 0, stop_after = -1;
  bit corrupt_en = 0;
  logic [AW-1:0] corrupt_addr = '0;
  int out_cnt = 0, max_out = 0, stb_viol = 0, sel_viol = 0, rd_acks = 0, quiet_edge = 0;

  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] data; int due; } req_t;
  req_t pend[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  function automatic logic [DW-1:0] model_pat(logic [AW-1:0] a, logic [31:0] s);
    logic [DW-1:0] d;
    logic [31:0] a32;
    a32 = 32'(a);
    for (int k = 0; k < int'(LANES); k++)
      d[32*k +: 32] = (a32 * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA77) ^ s;
    return d;
  endfunction

  function automatic logic [AW-1:0] model_addr(int i, bit m, logic [AW-1:0] b);
    int off;
    off = m ? (i * int'(STRIDE)) % int'(N) : i;
    return b + AW'(off);
  endfunction

  // number of recorded bus transactions that deviate from the expected pass
  function automatic int seq_errs(bit m, logic [31:0] s, logic [AW-1:0] b);
    int e;
    logic [AW-1:0] a;
    e = 0;
    if (wr_addr_q.size() != int'(N) || rd_addr_q.size() != int'(N)) return int'(N);
    for (int i = 0; i < int'(N); i++) begin
      a = model_addr(i, m, b);
      if (wr_addr_q[i] !== a) e++;
      if (rd_addr_q[i] !== a) e++;
      if (wr_data_q[i] !== model_pat(a, s)) e++;
    end
    return e;
  endfunction

  initial begin : slave
    req_t r;
    slv_stall = 1'b0; slv_ack = 1'b0; slv_rdata = '0;
    forever begin
      @(negedge clk);
      if (!cyc) begin
        pend.delete(); out_cnt = 0; slv_ack = 1'b0; slv_stall = 1'b0;
      end else begin
        if (out_cnt == 0) quiet_edge = cycle + 1;
        if (out_cnt > max_out) max_out = out_cnt;
        if (out_cnt >= int'(MAXO) && stb) stb_viol++;
        if (stb && sel !== '1) sel_viol++;
        slv_ack = 1'b0;
        slv_stall = ($urandom_range(99) < stall_pct);
        if (pend.size() > 0 && pend[0].due <= cycle &&
            (pend[0].we || stop_after < 0 || rd_acks < stop_after)) begin
          r = pend.pop_front();
          slv_ack = 1'b1; slv_rdata = r.data; out_cnt--; quiet_edge = cycle + 1;
          if (!r.we) rd_acks++;
        end
        if (stb && !slv_stall) begin
          r.addr = wb_addr; r.we = we; r.due = cycle + lat;
          if (we) begin
            r.data = '0; mem[wb_addr] = wb_data;
            wr_addr_q.push_back(wb_addr); wr_data_q.push_back(wb_data);
          end else begin
            r.data = mem.exists(wb_addr) ? mem[wb_addr] : '0;
            if (corrupt_en && wb_addr == corrupt_addr) r.data[96 +: 32] = ~r.data[96 +: 32];
            rd_addr_q.push_back(wb_addr);
          end
          pend.push_back(r); out_cnt++;
        end
      end
    end
  end

  task automatic start_pass(bit m, logic [31:0] s, logic [AW-1:0] b);
    wr_addr_q.delete(); rd_addr_q.delete(); wr_data_q.delete();
    rd_acks = 0; max_out = 0; stb_viol = 0; sel_viol = 0;
    @(negedge clk);
    mode = m; seed = s; base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int maxc, output bit ok, output int cnt, output int done_edge);
    ok = 0; cnt = maxc; done_edge = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; cnt = c + 1; done_edge = cycle; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({cyc, stb, we, busy, done, pass, tmo} !== 7'd0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {cyc, stb, we, busy, done, pass, tmo}); end
    n_cmp++; if (err !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err); end
    n_cmp++; if (ferr !== '0) begin n_fail++; $display("FAIL reset_ferr: got %0h want 0", ferr); end
    n_cmp++; if (wb_addr !== '0 || sel !== '0) begin n_fail++;
      $display("FAIL reset_bus: addr %0h sel %0h want 0", wb_addr, sel); end
    n_cmp++; if (wb_data !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero want 0"); end
  endtask

  task automatic test_ideal();
    bit ok; int cnt, de, se;
    lat = 1; stall_pct = 0;
    start_pass(1'b0, 32'h0, '0);
    n_cmp++; if (busy !== 1'b1 || cyc !== 1'b1) begin n_fail++;
      $display("FAIL ideal_busy: busy %b cyc %b want 1 1", busy, cyc); end
    wait_done(3000, ok, cnt, de);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ideal_done: no done within 3000 cycles"); end
    n_cmp++; if (pass !== 1'b1 || err !== 16'd0 || tmo !== 1'b0) begin n_fail++;
      $display("FAIL ideal_status: pass %b err %0d tmo %b want 1 0 0", pass, err, tmo); end
    se = seq_errs(1'b0, 32'h0, '0);
    n_cmp++; if (se != 0) begin n_fail++; $display("FAIL ideal_seq: got %0d bad transfers want 0", se); end
    n_cmp++; if (cnt < 512 || cnt > 530) begin n_fail++;
      $display("FAIL ideal_cycles: got %0d want 512..530", cnt); end
    n_cmp++; if (busy !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0) begin n_fail++;
      $display("FAIL ideal_idle: busy %b cyc %b stb %b want 0 0 0", busy, cyc, stb); end
  endtask

  task automatic test_idle_ack();
    @(negedge clk);
    for (int k = 0; k < int'(LANES); k++) inj_data[32*k +: 32] = $urandom;
    inj_ack = 1'b1;
    repeat (3) @(negedge clk);
    inj_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (err !== 16'd0 || pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack: err %0d pass %b done %b busy %b cyc %b want 0 1 1 0 0",
                         err, pass, done, busy, cyc); end
  endtask

  task automatic test_latency();
    bit ok; int cnt, de, se;
    logic [31:0] s;
    s = $urandom; lat = 40; stall_pct = 0;
    start_pass(1'b0, s, '0);
    repeat (100) @(negedge clk);
    seed = ~s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6000, ok, cnt, de);
    n_cmp++; if (!ok || pass !== 1'b1) begin n_fail++;
      $display("FAIL lat_pass: done %b pass %b want 1 1", ok, pass); end
    n_cmp++; if (max_out != int'(MAXO)) begin n_fail++;
      $display("FAIL lat_max_out: got %0d want %0d", max_out, MAXO); end
    n_cmp++; if (stb_viol != 0 || sel_viol != 0) begin n_fail++;
      $display("FAIL lat_stb_sel: stb_at_max %0d sel_bad %0d want 0 0", stb_viol, sel_viol); end
    se = seq_errs(1'b0, s, '0);
    n_cmp++; if (se != 0) begin n_fail++; $display("FAIL lat_seq: got %0d bad transfers want 0", se); end
  endtask

  task automatic test_scattered();
    bit ok; int cnt, de, se, bad;
    bit seen [logic [AW-1:0]];
    logic [31:0] s;
    s = $urandom; lat = 2; stall_pct = 20;
    start_pass(1'b1, s, 24'h100);
    wait_done(4000, ok, cnt, de);
    n_cmp++; if (!ok || pass !== 1'b1) begin n_fail++;
      $display("FAIL scat_pass: done %b pass %b want 1 1", ok, pass); end
    n_cmp++; if (wr_addr_q.size() < 3 || wr_addr_q[0] !== 24'h100 || wr_addr_q[1] !== 24'h125 ||
                 wr_addr_q[2] !== 24'h14A) begin n_fail++;
      $display("FAIL scat_first: got %0h %0h %0h want 100 125 14a",
               wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]); end
    bad = 0;
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] < 24'h100 || wr_addr_q[i] > 24'h1FF) bad++;
      seen[wr_addr_q[i]] = 1'b1;
    end
    n_cmp++; if (seen.num() != int'(N) || bad != 0) begin n_fail++;
      $display("FAIL scat_distinct: distinct %0d out_of_range %0d want 256 0", seen.num(), bad); end
    se = seq_errs(1'b1, s, 24'h100);
    n_cmp++; if (se != 0) begin n_fail++; $display("FAIL scat_seq: got %0d bad transfers want 0", se); end
    stall_pct = 0;
  endtask

  task automatic test_corrupt();
    bit ok; int cnt, de, exp_err;
    lat = 1; corrupt_en = 1'b1; corrupt_addr = 24'd5;
    exp_err = 0;
    for (int i = 0; i < int'(N); i++) if (model_addr(i, 1'b0, '0) == corrupt_addr) exp_err++;
    start_pass(1'b0, $urandom, '0);
    wait_done(3000, ok, cnt, de);
    n_cmp++; if (!ok || int'(err) != exp_err) begin n_fail++;
      $display("FAIL corrupt_err: done %b err %0d want 1 %0d", ok, err, exp_err); end
    n_cmp++; if (ferr !== corrupt_addr) begin n_fail++;
      $display("FAIL corrupt_addr: got %0h want %0h", ferr, corrupt_addr); end
    n_cmp++; if (pass !== 1'b0 || tmo !== 1'b0) begin n_fail++;
      $display("FAIL corrupt_status: pass %b tmo %b want 0 0", pass, tmo); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok; int cnt, de;
    lat = 1; stall_pct = 50; stop_after = 10;
    start_pass(1'b0, $urandom, '0);
    wait_done(20000, ok, cnt, de);
    n_cmp++; if (!ok || tmo !== 1'b1) begin n_fail++;
      $display("FAIL tmo_flag: done %b timeout %b want 1 1", ok, tmo); end
    n_cmp++; if (pass !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL tmo_bus: pass %b cyc %b stb %b busy %b want 0 0 0 0", pass, cyc, stb, busy); end
    n_cmp++; if (err !== 16'd0) begin n_fail++; $display("FAIL tmo_err: got %0d want 0", err); end
    n_cmp++; if (de - quiet_edge != int'(TO)) begin n_fail++;
      $display("FAIL tmo_cycles: got %0d want %0d", de - quiet_edge, TO); end
    stall_pct = 0; stop_after = -1;
  endtask

  task automatic test_reset_mid_read();
    bit ok, reached; int cnt, de, se;
    lat = 3;
    start_pass(1'b0, $urandom, '0);
    reached = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rd_addr_q.size() >= 20) begin reached = 1; break; end
    end
    n_cmp++; if (!reached) begin n_fail++; $display("FAIL rst_reach_read: got no read phase want reads"); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({cyc, stb, busy, done} !== 4'd0 || err !== 16'd0) begin n_fail++;
      $display("FAIL rst_mid: cyc %b stb %b busy %b done %b err %0d want all 0", cyc, stb, busy, done, err); end
    rst = 1'b0;
    start_pass(1'b0, 32'hDEADBEEF, '0);
    wait_done(3000, ok, cnt, de);
    n_cmp++; if (!ok || pass !== 1'b1 || err !== 16'd0 || tmo !== 1'b0) begin n_fail++;
      $display("FAIL rst_restart: done %b pass %b err %0d tmo %b want 1 1 0 0", ok, pass, err, tmo); end
    se = seq_errs(1'b0, 32'hDEADBEEF, '0);
    n_cmp++; if (se != 0) begin n_fail++; $display("FAIL rst_seq: got %0d bad transfers want 0", se); end
  endtask

  task automatic test_random();
    bit ok, m; int cnt, de, se;
    logic [31:0] s;
    logic [AW-1:0] b;
    for (int it = 0; it < 4; it++) begin
      m = 1'($urandom_range(1));
      s = $urandom;
      b = (it % 2 == 0) ? AW'($urandom) : (24'hFFFFFF - AW'($urandom_range(200)));
      lat = int'($urandom_range(6, 1));
      stall_pct = int'($urandom_range(40));
      start_pass(m, s, b);
      wait_done(5000, ok, cnt, de);
      se = seq_errs(m, s, b);
      n_cmp++; if (!ok || pass !== 1'b1 || se != 0) begin n_fail++;
        $display("FAIL rand_%0d: done %b pass %b bad %0d want 1 1 0", it, ok, pass, se); end
      n_cmp++; if (max_out > int'(MAXO) || stb_viol != 0) begin n_fail++;
        $display("FAIL rand_out_%0d: max %0d stb_at_max %0d want <=%0d 0", it, max_out, stb_viol, MAXO); end
    end
    stall_pct = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; base = '0;
    inj_ack = 1'b0; inj_data = '0;
    test_reset();
    test_ideal();
    test_idle_ack();
    test_latency();
    test_scattered();
    test_corrupt();
    test_timeout();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
